// File: rtl/toggle_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : toggle_debouncer
// Purpose  : Converts a raw, bouncy, asynchronous button level into a clean
//            single-cycle toggle strobe for a downstream toggle flip-flop
//            that is clocked by the same Clk. The input is synchronised
//            through two flops. Both edges are then debounced by a
//            counter-based FSM.
// Options  : Define TOGGLE_AUTOREPEAT_EN to emit a repeat strobe every
//            REPEAT_CYCLES cycles while the button stays held. Without it,
//            exactly one strobe is issued per accepted press.
// Params   : DEBOUNCE_CYCLES (>= 2) stable cycles to accept press/release
//            REPEAT_CYCLES   (>= 2) auto-repeat period (macro builds only)
// Ports    : Clk    in   rising-edge clock
//            Reset  in   asynchronous, active-high reset
//            Btn    in   raw button level, 1 = pressed
//            T      out  registered one-cycle toggle strobe
//            Stable out  registered debounced button level
//            Busy   out  registered, high while a press/release is qualified
// Revision : 1.0 - initial release
// ============================================================================
module toggle_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn,
    output logic T,
    output logic Stable,
    output logic Busy
);

    // The counter is sized for the longer of the two intervals.
    localparam int C_MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                  DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES) + 1;

    localparam logic [C_CNT_W-1:0] C_DEB_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = {C_CNT_W{1'b1}};
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
`ifdef TOGGLE_AUTOREPEAT_EN
    localparam logic [C_CNT_W-1:0] C_REP_LAST = C_CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 s1_q;
    logic                 btn_s_q;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [C_CNT_W-1:0]   count_inc;
    logic                 t_q, t_d;
    logic                 stable_q, stable_d;
    logic                 busy_q, busy_d;

    // ------------------------------------------------------------------
    // Two-flop synchroniser: only btn_s_q is seen by the FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q    <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            s1_q    <= Btn;
            btn_s_q <= s1_q;
        end
    end

    // Saturating increment: the counter must never wrap back to zero.
    assign count_inc = (count_q == C_CNT_MAX) ? count_q : (count_q + C_CNT_ONE);

    // ------------------------------------------------------------------
    // FSM state, counter and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            t_q      <= 1'b0;
            stable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            t_q      <= t_d;
            stable_q <= stable_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Outputs are derived from the next state, so the
    // registered outputs always line up with the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        t_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_s_q) begin
                    state_d = ST_PRESS_WAIT;
                    count_d = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (!btn_s_q) begin
                    // Bounce: the press is dropped and no strobe is issued.
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q >= C_DEB_LAST) begin
                    state_d = ST_HELD;
                    t_d     = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end

            ST_HELD: begin
                if (!btn_s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    count_d = '0;
                end else begin
`ifdef TOGGLE_AUTOREPEAT_EN
                    // Entering HELD always leaves count at 0, so a repeat
                    // strobe can never follow the press strobe directly.
                    if (count_q >= C_REP_LAST) begin
                        t_d     = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
`else
                    count_d = '0;
`endif
                end
            end

            ST_RELEASE_WAIT: begin
                if (btn_s_q) begin
                    // Release glitch: go back to HELD silently. Clearing
                    // count restarts any auto-repeat interval.
                    state_d = ST_HELD;
                    count_d = '0;
                end else if (count_q >= C_DEB_LAST) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        stable_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
        busy_d   = (state_d == ST_PRESS_WAIT) || (state_d == ST_RELEASE_WAIT);
    end

    assign T      = t_q;
    assign Stable = stable_q;
    assign Busy   = busy_q;

endmodule
`default_nettype wire
